// File: rtl/alu_ctrl_if.sv
// Instruction handshake and ALU operand/result bus for alu_ctrl.
// The controller takes the slave view; the instruction source and the ALU take the master view.
interface alu_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [15:0]      instr;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [7:0]       alu_opcode;
    logic [WIDTH-1:0] alu_c;
    logic [4:0]       alu_flags;

    modport master (
        output instr, instr_valid, alu_c, alu_flags,
        input  instr_ready, alu_a, alu_b, alu_opcode
    );

    modport slave (
        input  instr, instr_valid, alu_c, alu_flags,
        output instr_ready, alu_a, alu_b, alu_opcode
    );
endinterface

// File: rtl/alu_ctrl.sv
// Sequencing front end for the combinational ALU: accepts one instruction, drives the ALU
// from a 16x16 register file, then writes back the result and the PSR (IDLE -> EXEC -> WB).
module alu_ctrl #(
    parameter int WIDTH = 16,
    parameter int NREG  = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_ctrl_if.slave        bus,
    output logic [4:0]       psr,
    output logic             done,
    output logic             illegal,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [4:0]       flg_q, flg_d;
    logic [4:0]       psr_q, psr_d;
    logic [WIDTH-1:0] reg_q [NREG];
    logic [WIDTH-1:0] reg_d [NREG];

    logic [3:0] op, rd, ext, rs;
    logic [3:0] upd_code;
    logic       reg_form, op_illegal, is_cmp, psr_upd, wr_en;

    assign op  = ir_q[15:12];
    assign rd  = ir_q[11:8];
    assign ext = ir_q[7:4];
    assign rs  = ir_q[3:0];

    // Register/shift forms carry the real operation in op-ext; immediate forms in op itself.
    always_comb begin
        reg_form   = (op == 4'b0000) || (op == 4'b1000);
        upd_code   = (op == 4'b0000) ? ext : op;
        op_illegal = 1'b0;
        case (op)
            4'b0100, 4'b1100: op_illegal = 1'b1;
            4'b0000: op_illegal = !(ext inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
                                                4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1101});
            4'b1000: op_illegal = !(ext inside {4'b0000, 4'b0001, 4'b0010, 4'b0011,
                                                4'b0100, 4'b0110});
            default: op_illegal = 1'b0;
        endcase
        is_cmp  = (upd_code == 4'b1011);
        psr_upd = !op_illegal && (upd_code inside {4'b0001, 4'b0101, 4'b0111,
                                                   4'b1001, 4'b1010, 4'b1011});
        wr_en   = !op_illegal && !is_cmp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.instr_valid) state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.instr_ready = (state_q == IDLE);
        done            = (state_q == WB);
        illegal         = (state_q == WB) && op_illegal;
        bus.alu_opcode  = '0;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        if (state_q == EXEC) begin
            bus.alu_opcode = {op, ext};
            bus.alu_a      = reg_q[rd];
            bus.alu_b      = reg_form ? reg_q[rs] : {{(WIDTH-8){1'b0}}, ir_q[7:0]};
        end
    end

    // Operands are read in EXEC and the write lands only at the end of WB, so Rdest==Rsrc is safe.
    always_comb begin
        ir_d  = ir_q;
        res_d = res_q;
        flg_d = flg_q;
        reg_d = reg_q;
        psr_d = psr_q;
        case (state_q)
            IDLE: if (bus.instr_valid) ir_d = bus.instr;
            EXEC: begin
                res_d = bus.alu_c;
                flg_d = bus.alu_flags;
            end
            WB: begin
                if (wr_en)   reg_d[rd] = res_q;
                if (psr_upd) psr_d     = flg_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q  <= '0;
            res_q <= '0;
            flg_q <= '0;
            psr_q <= '0;
            for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
        end else begin
            ir_q  <= ir_d;
            res_q <= res_d;
            flg_q <= flg_d;
            psr_q <= psr_d;
            reg_q <= reg_d;
        end
    end

    assign psr      = psr_q;
    assign dbg_data = reg_q[dbg_addr];

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: a small behavioural ALU answers the controller, and
// hand-derived expectations are queued at issue and popped when the instruction retires.
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  psr;
    logic        done;
    logic        illegal;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    alu_ctrl_if #(.WIDTH(16)) bus ();

    alu_ctrl #(.WIDTH(16), .NREG(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .psr      (psr),
        .done     (done),
        .illegal  (illegal),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic        ill;
        logic [3:0]  rd;
        logic [15:0] val;
        logic [4:0]  psr;
    } sb_t;

    sb_t sb[$];

    // Stand-in ALU; unknown opcodes return a^b with every flag set so stray writes show up.
    function automatic logic [20:0] alu_model(input logic [7:0] opc, input logic [15:0] a,
                                              input logic [15:0] b);
        logic [16:0] sum;
        logic [15:0] r;
        logic [4:0]  f;
        sum = 17'd0;
        casez (opc)
            8'h05, 8'b0101_????: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[15:0];
                f   = {sum[16], 1'b0, (a[15] == b[15]) && (r[15] != a[15]), r == 16'h0, r[15]};
            end
            8'h0B, 8'b1011_????: begin
                r = a - b;
                f = {1'b0, a < b, 1'b0, a == b, $signed(a) < $signed(b)};
            end
            8'h01, 8'b0001_????: begin r = a & b; f = {3'b000, r == 16'h0, r[15]}; end
            8'h02, 8'b0010_????: begin r = a | b; f = {3'b000, r == 16'h0, r[15]}; end
            8'h0D, 8'b1101_????: begin r = b;     f = {3'b000, r == 16'h0, r[15]}; end
            8'b1111_????:        begin r = {b[7:0], 8'h00}; f = 5'b00000; end
            default:             begin r = a ^ b; f = 5'b11111; end
        endcase
        return {f, r};
    endfunction

    always_comb {bus.alu_flags, bus.alu_c} = alu_model(bus.alu_opcode, bus.alu_a, bus.alu_b);

    function automatic sb_t mk(input logic [15:0] instr, input logic [7:0] opc,
                               input logic [15:0] a, input logic [15:0] b, input logic ill,
                               input logic [3:0] rd, input logic [15:0] val,
                               input logic [4:0] p);
        sb_t e;
        e.instr = instr; e.opc = opc; e.a = a; e.b = b;
        e.ill = ill; e.rd = rd; e.val = val; e.psr = p;
        return e;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = i[3:0];
            #1;
            check_output($sformatf("%s_r%0d", tag, i), dbg_data, 32'h0);
        end
    endtask

    // Issue one instruction, check the EXEC-cycle ALU drive, then the WB pulse and the retired state.
    task automatic apply_stimulus(input sb_t e);
        sb_t cur;
        int  waited;
        waited = 0;
        sb.push_back(e);
        @(negedge clk);
        bus.instr       = e.instr;
        bus.instr_valid = 1'b1;
        while (bus.instr_ready !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check_output("accept_wait", waited, (waited < 8) ? waited : 0);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        cur = sb[0];
        check_output("exec_opcode", bus.alu_opcode, cur.opc);
        check_output("exec_a", bus.alu_a, cur.a);
        check_output("exec_b", bus.alu_b, cur.b);
        check_output("exec_ready", bus.instr_ready, 1'b0);
        check_output("exec_done", done, 1'b0);
        @(posedge clk);
        #1;
        check_output("wb_done", done, 1'b1);
        check_output("wb_illegal", illegal, cur.ill);
        check_output("wb_opcode_idle", bus.alu_opcode, 8'h00);
        cur = sb.pop_front();
        @(posedge clk);
        #1;
        dbg_addr = cur.rd;
        #1;
        check_output($sformatf("reg_r%0d_%h", cur.rd, cur.instr), dbg_data, cur.val);
        check_output($sformatf("psr_%h", cur.instr), psr, cur.psr);
        check_output("idle_done", done, 1'b0);
        check_output("idle_illegal", illegal, 1'b0);
        check_output("idle_ready", bus.instr_ready, 1'b1);
    endtask

    initial begin
        reset           = 1'b1;
        bus.instr       = 16'h0000;
        bus.instr_valid = 1'b0;
        dbg_addr        = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_output("rst_psr", psr, 5'b00000);
        check_output("rst_ready", bus.instr_ready, 1'b1);
        check_output("rst_done", done, 1'b0);
        check_output("rst_illegal", illegal, 1'b0);
        check_output("rst_alu_a", bus.alu_a, 16'h0);
        check_output("rst_alu_b", bus.alu_b, 16'h0);
        check_output("rst_opcode", bus.alu_opcode, 8'h00);
        check_regs_zero("rst");

        apply_stimulus(mk(16'hD17F, 8'hD7, 16'h0000, 16'h007F, 1'b0, 4'd1, 16'h007F, 5'b00000));
        apply_stimulus(mk(16'hF17F, 8'hF7, 16'h007F, 16'h007F, 1'b0, 4'd1, 16'h7F00, 5'b00000));
        apply_stimulus(mk(16'h21FF, 8'h2F, 16'h7F00, 16'h00FF, 1'b0, 4'd1, 16'h7FFF, 5'b00000));
        apply_stimulus(mk(16'hD201, 8'hD0, 16'h0000, 16'h0001, 1'b0, 4'd2, 16'h0001, 5'b00000));
        apply_stimulus(mk(16'h0152, 8'h05, 16'h7FFF, 16'h0001, 1'b0, 4'd1, 16'h8000, 5'b00101));
        apply_stimulus(mk(16'hD305, 8'hD0, 16'h0000, 16'h0005, 1'b0, 4'd3, 16'h0005, 5'b00101));
        apply_stimulus(mk(16'hB305, 8'hB0, 16'h0005, 16'h0005, 1'b0, 4'd3, 16'h0005, 5'b00010));
        apply_stimulus(mk(16'h4000, 8'h40, 16'h0000, 16'h0000, 1'b1, 4'd0, 16'h0000, 5'b00010));
        apply_stimulus(mk(16'h8102, 8'h80, 16'h8000, 16'h0001, 1'b0, 4'd1, 16'h8001, 5'b00010));
        apply_stimulus(mk(16'h01F2, 8'h0F, 16'h8001, 16'h0001, 1'b1, 4'd1, 16'h8001, 5'b00010));
        apply_stimulus(mk(16'h8172, 8'h87, 16'h8001, 16'h0001, 1'b1, 4'd1, 16'h8001, 5'b00010));
        apply_stimulus(mk(16'h0111, 8'h01, 16'h8001, 16'h8001, 1'b0, 4'd1, 16'h8001, 5'b00001));
        apply_stimulus(mk(16'h12F0, 8'h1F, 16'h0001, 16'h00F0, 1'b0, 4'd2, 16'h0000, 5'b00010));
        apply_stimulus(mk(16'hD409, 8'hD0, 16'h0000, 16'h0009, 1'b0, 4'd4, 16'h0009, 5'b00010));

        // ADDI R4,1 is aborted by reset while in EXEC.
        @(negedge clk);
        bus.instr       = 16'h5401;
        bus.instr_valid = 1'b1;
        check_output("abort_ready", bus.instr_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        check_output("abort_exec_opcode", bus.alu_opcode, 8'h50);
        check_output("abort_exec_a", bus.alu_a, 16'h0009);
        check_output("abort_exec_b", bus.alu_b, 16'h0001);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_output("abort_done", done, 1'b0);
        check_output("abort_psr", psr, 5'b00000);
        check_output("abort_ready_after", bus.instr_ready, 1'b1);
        check_output("abort_opcode", bus.alu_opcode, 8'h00);
        check_regs_zero("abort");

        apply_stimulus(mk(16'hD4AA, 8'hDA, 16'h0000, 16'h00AA, 1'b0, 4'd4, 16'h00AA, 5'b00000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
